wdt_kick_gen: RTL and testbench
===============================

# wdt_kick_gen

Watchdog servicing block: the kicking end of the watchdog interface. It issues a one-cycle `kick` pulse at a programmable interval, but only when the application has proven liveness (`app_alive`) within the current window. It records missed windows and reacts to the watchdog's `wd_bark` timeout. It sits beside the watchdog inside the tile and is driven by application logic plus configuration pins.

## Interface
- `DEFAULT_PERIOD`, 16: reset value of the period register (8-bit; 0 encodes 256).
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ena` in 1: block enable; low forces IDLE and releases the bark lock.
- `cfg_period` in 8: kick window length N; 0 means 256.
- `cfg_load` in 1: loads `cfg_period` into `period_reg`; honoured only in IDLE.
- `app_alive` in 1: liveness strobe from the application; level-sampled each cycle.
- `wd_bark` in 1: watchdog timeout indication.
- `clr` in 1: clears the sticky flags and `miss_count`.
- `kick` out 1: registered kick pulse, high exactly while state is KICK.
- `state` out 2: IDLE=00, RUN=01, KICK=10, STARVE=11.
- `kick_count` out 8: kicks issued; wraps 255→0.
- `miss_count` out 8: windows that expired without liveness; saturates at 255.
- `missed` out 1: sticky; at least one window expired without liveness.
- `barked` out 1: sticky; `wd_bark` was seen while active.

## Operation
- Reset values: state=IDLE, kick=0, cnt=0, alive_flag=0, `kick_count`=0, `miss_count`=0, `missed`=0, `barked`=0, lock=0, `period_reg`=DEFAULT_PERIOD.
- Internal registers: 8-bit `cnt`, `alive_flag`, `lock`, 8-bit `period_reg`.
- Terminal condition: `cnt` == `period_reg`−1 (mod 256).
- IDLE:
  - `cnt` and `alive_flag` are held at 0.
  - With `cfg_load`=1, `period_reg` ← `cfg_period`.
  - Goes to RUN when `ena`=1, lock=0 and `wd_bark`=0.
- RUN:
  - `cnt` increments each cycle.
  - `alive_flag` ← `alive_flag` | `app_alive`.
  - On terminal with (`alive_flag` | `app_alive`) → KICK.
  - On terminal without liveness → STARVE; `missed` is set and `miss_count` increments (saturating).
- KICK:
  - `kick`=1 and `kick_count` increments.
  - `cnt` ← 0 and `alive_flag` ← `app_alive`; a strobe during KICK counts toward the next window.
  - Next state is RUN.
- STARVE:
  - No kick; `cnt` is held.
  - `app_alive`=1 → KICK (late kick). Otherwise remain in STARVE; no further `miss_count` increments.
- Priority, highest first:
  1. `wd_bark`=1 in a non-IDLE state → IDLE; set `barked` and lock.
  2. `ena`=0 → IDLE.
  3. Normal transitions above.
- lock is cleared in any cycle with `ena`=0, so re-arming after a bark requires toggling `ena` low.
- `cfg_load` outside IDLE is ignored; `period_reg` is unchanged.
- `clr` clears `missed`, `barked` and `miss_count`. A same-cycle set event wins: the flag stays 1 and `miss_count` becomes 1. `clr` does not affect `kick_count` or lock.

## Timing
- Cycle 0 is the first cycle with state=RUN and `cnt`=0.
- With liveness present, `kick` is high in cycle N. Steady-state kicks are spaced N+1 cycles apart.
- N=1: RUN lasts one cycle, then KICK, giving a 2-cycle kick spacing.
- N=0 (256): terminal at `cnt`=255; `kick` is high in cycle 256.
- Late kick: `app_alive` sampled high in STARVE gives `kick`=1 in the next cycle.
- `wd_bark` or `ena`=0 sampled at edge t: state=IDLE and `kick`=0 from t on. A KICK already registered before t completes normally.
- `rst_n` low mid-operation: all outputs take their reset values immediately, independent of `clk`.
- `state`, `kick` and all counters and flags are registered outputs; there are no combinational input→output paths.

## Test plan
- Basic kicking: reset; `cfg_period`=4 with `cfg_load` in IDLE; `ena`=1; `app_alive` held 1 → `kick` pulses in cycles 4, 9, 14 (spacing 5); `kick_count`=3 after cycle 14; `missed`=0.
- Missed window: N=4, `app_alive`=0 → STARVE at cycle 4; `missed`=1, `miss_count`=1, no kick. `app_alive` pulse at cycle 10 → `kick` in cycle 11, then RUN with `cnt`=0.
- Bark lock: RUN with `wd_bark` pulsed 1 cycle → IDLE next cycle, `barked`=1. Stays IDLE with `ena`=1. `ena` 0 then 1 → RUN; `barked` remains 1 until `clr`.
- Config and boundaries:
  - `cfg_load` during RUN → ignored; original spacing kept.
  - `cfg_period`=0 → first kick at cycle 256.
  - `cfg_period`=1 → kicks every 2 cycles.
- Counter limits and `clr`:
  - 256 kicks → `kick_count` wraps to 0.
  - Force 300 misses (re-enter via `ena` toggle) → `miss_count`=255.
  - `clr` coincident with a new miss → `missed`=1, `miss_count`=1.
- Async reset: assert `rst_n`=0 mid-KICK, between clock edges → `kick`=0, `state`=00 and counters 0 immediately; `period_reg` returns to 16.

Source files
------------

// File: rtl/wdt_kick_gen_if.sv
// Signal bundle between the watchdog kicker and its application/configuration side.
// The kicker block connects through the slave modport; the driving side uses master.
interface wdt_kick_gen_if;
  logic       ena;
  logic [7:0] cfg_period;
  logic       cfg_load;
  logic       app_alive;
  logic       wd_bark;
  logic       clr;
  logic       kick;
  logic [1:0] state;
  logic [7:0] kick_count;
  logic [7:0] miss_count;
  logic       missed;
  logic       barked;

  modport master (
    output ena, cfg_period, cfg_load, app_alive, wd_bark, clr,
    input  kick, state, kick_count, miss_count, missed, barked
  );

  modport slave (
    input  ena, cfg_period, cfg_load, app_alive, wd_bark, clr,
    output kick, state, kick_count, miss_count, missed, barked
  );
endinterface

// File: rtl/wdt_kick_gen.sv
// Watchdog kicker: pulses kick once per window when the application has shown
// liveness, tracks missed windows, and locks out after a watchdog bark.
module wdt_kick_gen #(
  parameter logic [7:0] DEFAULT_PERIOD = 8'd16
) (
  input  logic           clk,
  input  logic           rst_n,
  wdt_kick_gen_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    KICK   = 2'b10,
    STARVE = 2'b11
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] period_q;
  logic [7:0] kick_count_q;
  logic [7:0] miss_count_q;
  logic       alive_q, alive_d;
  logic       lock_q;
  logic       kick_q;
  logic       missed_q;
  logic       barked_q;

  logic       terminal;
  logic       live;
  logic       bark_hit;
  logic       miss_ev;
  logic       kick_ev;

  // Period 0 wraps to 255 here, which gives the 256-cycle window for free.
  assign terminal = (cnt_q == period_q - 8'd1);
  assign live     = alive_q | bus.app_alive;
  assign bark_hit = bus.wd_bark && (state_q != IDLE);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    alive_d = alive_q;

    case (state_q)
      IDLE:    if (bus.ena && !lock_q && !bus.wd_bark) state_d = RUN;
      RUN:     if (terminal) state_d = live ? KICK : STARVE;
      KICK:    state_d = RUN;
      STARVE:  if (bus.app_alive) state_d = KICK;
      default: state_d = IDLE;
    endcase

    if (bark_hit || !bus.ena) state_d = IDLE;

    if (state_d == IDLE) begin
      cnt_d   = 8'd0;
      alive_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d   = 8'd0;
          alive_d = 1'b0;
        end
        RUN: begin
          cnt_d   = cnt_q + 8'd1;
          alive_d = live;
        end
        // A strobe seen during the kick cycle counts toward the next window.
        KICK: begin
          cnt_d   = 8'd0;
          alive_d = bus.app_alive;
        end
        default: ;
      endcase
    end
  end

  assign miss_ev = (state_q == RUN) && (state_d == STARVE);
  assign kick_ev = (state_d == KICK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      alive_q      <= 1'b0;
      lock_q       <= 1'b0;
      kick_q       <= 1'b0;
      period_q     <= DEFAULT_PERIOD;
      kick_count_q <= 8'd0;
      miss_count_q <= 8'd0;
      missed_q     <= 1'b0;
      barked_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      alive_q <= alive_d;
      kick_q  <= kick_ev;

      if (state_q == IDLE && bus.cfg_load) period_q <= bus.cfg_period;

      if (!bus.ena)     lock_q <= 1'b0;
      else if (bark_hit) lock_q <= 1'b1;

      if (kick_ev) kick_count_q <= kick_count_q + 8'd1;

      // A miss in the same cycle as clr wins: the count restarts at one.
      if (miss_ev) begin
        missed_q <= 1'b1;
        if (bus.clr)                   miss_count_q <= 8'd1;
        else if (miss_count_q != 8'hff) miss_count_q <= miss_count_q + 8'd1;
      end else if (bus.clr) begin
        missed_q     <= 1'b0;
        miss_count_q <= 8'd0;
      end

      if (bark_hit)     barked_q <= 1'b1;
      else if (bus.clr) barked_q <= 1'b0;
    end
  end

  assign bus.kick       = kick_q;
  assign bus.state      = state_q;
  assign bus.kick_count = kick_count_q;
  assign bus.miss_count = miss_count_q;
  assign bus.missed     = missed_q;
  assign bus.barked     = barked_q;

endmodule

// File: tb/tb_wdt_kick_gen.sv
// Self-checking bench for wdt_kick_gen: random liveness patterns against a
// window-level timeline model, plus directed bark, config, counter and reset cases.
module tb_wdt_kick_gen;

  logic clk = 1'b0;
  logic rst_n;
  wdt_kick_gen_if bus ();

  wdt_kick_gen #(.DEFAULT_PERIOD(8'd16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  bit         alive_v  [0:1023];
  bit         kick_exp [0:1023];
  logic [1:0] st_exp   [0:1023];
  int         exp_kicks;
  int         exp_misses;

  // Timeline model: walk window by window over a known liveness pattern.
  // An event caused at the edge closing cycle e takes effect only if e <= len-2,
  // because ena is dropped during the last cycle.
  task automatic build_model(input int n, input int len);
    int s, term, lo, t, k;
    bit fk, live;
    for (int i = 0; i < len; i++) begin
      kick_exp[i] = 1'b0;
      st_exp[i]   = 2'b01;
    end
    exp_kicks  = 0;
    exp_misses = 0;
    s  = 0;
    fk = 1'b0;
    while (1) begin
      term = s + n - 1;
      if (term > len - 2) break;
      lo   = fk ? s - 1 : s;
      live = 1'b0;
      for (int i = lo; i <= term; i++) live |= alive_v[i];
      if (live) begin
        k = term + 1;
      end else begin
        exp_misses++;
        t = term + 1;
        while (t <= len - 2 && !alive_v[t]) t++;
        if (t > len - 2) begin
          for (int i = term + 1; i < len; i++) st_exp[i] = 2'b11;
          break;
        end
        for (int i = term + 1; i <= t; i++) st_exp[i] = 2'b11;
        k = t + 1;
      end
      kick_exp[k] = 1'b1;
      st_exp[k]   = 2'b10;
      exp_kicks++;
      s  = k + 1;
      fk = 1'b1;
    end
  endtask

  task automatic do_reset();
    bus.ena        = 1'b0;
    bus.cfg_period = 8'd0;
    bus.cfg_load   = 1'b0;
    bus.app_alive  = 1'b0;
    bus.wd_bark    = 1'b0;
    bus.clr        = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // pct < 0 keeps the liveness pattern already placed in alive_v.
  task automatic run_case(input string name, input bit do_load, input int n_cfg,
                          input int len, input int pct);
    int n_eff;
    int sat;
    n_eff = do_load ? ((n_cfg == 0) ? 256 : n_cfg) : 16;
    if (pct >= 0)
      for (int i = 0; i < len; i++) alive_v[i] = (int'($urandom_range(99)) < pct);
    build_model(n_eff, len);
    do_reset();
    if (do_load) begin
      @(negedge clk);
      bus.cfg_period = n_cfg[7:0];
      bus.cfg_load   = 1'b1;
    end
    @(negedge clk);
    bus.cfg_load = 1'b0;
    bus.ena      = 1'b1;
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      n_checks++;
      if (bus.state !== st_exp[c])
        $display("FAIL %s state c=%0d: got %0d want %0d", name, c, bus.state, st_exp[c]);
      else n_pass++;
      n_checks++;
      if (bus.kick !== kick_exp[c])
        $display("FAIL %s kick c=%0d: got %0d want %0d", name, c, bus.kick, kick_exp[c]);
      else n_pass++;
      bus.app_alive = alive_v[c];
      bus.ena       = (c != len - 1);
    end
    @(negedge clk);
    bus.app_alive = 1'b0;
    sat = (exp_misses > 255) ? 255 : exp_misses;
    n_checks++;
    if (bus.state !== 2'b00) $display("FAIL %s end state: got %0d want 0", name, bus.state);
    else n_pass++;
    n_checks++;
    if (bus.kick_count !== exp_kicks[7:0])
      $display("FAIL %s kick_count: got %0d want %0d", name, bus.kick_count, exp_kicks[7:0]);
    else n_pass++;
    n_checks++;
    if (bus.miss_count !== sat[7:0])
      $display("FAIL %s miss_count: got %0d want %0d", name, bus.miss_count, sat);
    else n_pass++;
    n_checks++;
    if (bus.missed !== (exp_misses > 0))
      $display("FAIL %s missed: got %0d want %0d", name, bus.missed, exp_misses > 0);
    else n_pass++;
    n_checks++;
    if (bus.barked !== 1'b0) $display("FAIL %s barked: got %0d want 0", name, bus.barked);
    else n_pass++;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_checks++;
    if ({bus.state, bus.kick, bus.missed, bus.barked} !== 5'b0)
      $display("FAIL reset flags: got %b want 00000",
               {bus.state, bus.kick, bus.missed, bus.barked});
    else n_pass++;
    n_checks++;
    if ({bus.kick_count, bus.miss_count} !== 16'h0)
      $display("FAIL reset counters: got %h want 0000", {bus.kick_count, bus.miss_count});
    else n_pass++;
  endtask

  task automatic test_timing();
    run_case("default_period", 1'b0, 0, 40, 100);
    run_case("basic", 1'b1, 4, 15, 100);
    for (int i = 0; i < 1024; i++) alive_v[i] = 1'b0;
    alive_v[10] = 1'b1;
    run_case("missed", 1'b1, 4, 20, -1);
    run_case("period1", 1'b1, 1, 20, 100);
    run_case("period0", 1'b1, 0, 260, 100);
  endtask

  task automatic test_random();
    for (int r = 0; r < 5; r++)
      run_case("random", 1'b1, int'($urandom_range(1, 6)), 80, int'($urandom_range(5, 90)));
    run_case("sparse", 1'b1, 3, 60, 4);
  endtask

  task automatic test_bark();
    do_reset();
    @(negedge clk);
    bus.cfg_period = 8'd4;
    bus.cfg_load   = 1'b1;
    @(negedge clk);
    bus.cfg_load  = 1'b0;
    bus.ena       = 1'b1;
    bus.app_alive = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.wd_bark = 1'b1;
    @(negedge clk);
    bus.wd_bark = 1'b0;
    n_checks++;
    if (bus.state !== 2'b00 || bus.barked !== 1'b1)
      $display("FAIL bark entry: got state=%0d barked=%0d want 0/1", bus.state, bus.barked);
    else n_pass++;
    repeat (4) @(negedge clk);
    n_checks++;
    if (bus.state !== 2'b00) $display("FAIL bark lock: got state=%0d want 0", bus.state);
    else n_pass++;
    bus.ena = 1'b0;
    @(negedge clk);
    bus.ena = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.state !== 2'b01 || bus.barked !== 1'b1)
      $display("FAIL bark rearm: got state=%0d barked=%0d want 1/1", bus.state, bus.barked);
    else n_pass++;
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    n_checks++;
    if (bus.barked !== 1'b0) $display("FAIL bark clr: got %0d want 0", bus.barked);
    else n_pass++;
    bus.ena = 1'b0;
  endtask

  task automatic test_cfg_load_in_run();
    do_reset();
    @(negedge clk);
    bus.cfg_period = 8'd4;
    bus.cfg_load   = 1'b1;
    @(negedge clk);
    bus.cfg_load  = 1'b0;
    bus.ena       = 1'b1;
    bus.app_alive = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      n_checks++;
      if (bus.kick !== (c % 5 == 4))
        $display("FAIL cfg_in_run kick c=%0d: got %0d want %0d", c, bus.kick, c % 5 == 4);
      else n_pass++;
      bus.cfg_load   = (c == 1);
      bus.cfg_period = 8'd7;
    end
    bus.cfg_load = 1'b0;
    bus.ena      = 1'b0;
  endtask

  task automatic test_kick_wrap();
    run_case("kick_wrap", 1'b1, 1, 513, 100);
  endtask

  task automatic test_miss_saturate();
    do_reset();
    @(negedge clk);
    bus.cfg_period = 8'd1;
    bus.cfg_load   = 1'b1;
    @(negedge clk);
    bus.cfg_load = 1'b0;
    for (int it = 0; it < 300; it++) begin
      bus.ena = 1'b1;
      @(negedge clk);
      @(negedge clk);
      bus.ena = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if (bus.miss_count !== 8'd255 || bus.missed !== 1'b1)
      $display("FAIL miss_sat: got count=%0d missed=%0d want 255/1", bus.miss_count, bus.missed);
    else n_pass++;
    bus.ena = 1'b1;
    @(negedge clk);
    bus.clr = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.state !== 2'b11 || bus.miss_count !== 8'd1 || bus.missed !== 1'b1)
      $display("FAIL clr_vs_miss: got state=%0d count=%0d missed=%0d want 3/1/1",
               bus.state, bus.miss_count, bus.missed);
    else n_pass++;
    @(negedge clk);
    bus.clr = 1'b0;
    n_checks++;
    if (bus.state !== 2'b11 || bus.miss_count !== 8'd0 || bus.missed !== 1'b0)
      $display("FAIL clr_in_starve: got state=%0d count=%0d missed=%0d want 3/0/0",
               bus.state, bus.miss_count, bus.missed);
    else n_pass++;
    bus.ena = 1'b0;
  endtask

  task automatic test_async_reset();
    bit seen;
    int first;
    do_reset();
    @(negedge clk);
    bus.cfg_period = 8'd2;
    bus.cfg_load   = 1'b1;
    @(negedge clk);
    bus.cfg_load  = 1'b0;
    bus.ena       = 1'b1;
    bus.app_alive = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bus.kick;
    end
    n_checks++;
    if (!seen || bus.kick_count !== 8'd1)
      $display("FAIL areset pre-kick: got seen=%0d count=%0d want 1/1", seen, bus.kick_count);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.state, bus.kick, bus.missed, bus.barked, bus.kick_count, bus.miss_count} !== 21'h0)
      $display("FAIL areset outputs: got state=%0d kick=%0d count=%0d want 0/0/0",
               bus.state, bus.kick, bus.kick_count);
    else n_pass++;
    bus.ena = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.ena = 1'b1;
    first = -1;
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (bus.kick === 1'b1 && first < 0) first = c;
    end
    n_checks++;
    if (first != 16) $display("FAIL areset period: got first kick=%0d want 16", first);
    else n_pass++;
    bus.ena       = 1'b0;
    bus.app_alive = 1'b0;
  endtask

  initial begin
    test_reset();
    test_timing();
    test_random();
    test_bark();
    test_cfg_load_in_run();
    test_kick_wrap();
    test_miss_saturate();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
